// File: rtl/psr_branch_resolver.sv
// Branch resolver: latches ALU flags into a masked PSR, evaluates 4-bit condition
// codes (with same-cycle flag bypass) and returns a registered decision to fetch.
module psr_branch_resolver #(
  parameter int BITSIZE = 16,
  parameter int CNT_EN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BITSIZE-1:0] flags_in,
  input  logic               flags_we,
  input  logic               flags_pending,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_cond,
  input  logic [BITSIZE-1:0] req_target,
  output logic               br_valid,
  input  logic               br_ready,
  output logic               br_taken,
  output logic [BITSIZE-1:0] br_target,
  output logic [BITSIZE-1:0] psr,
  output logic [BITSIZE-1:0] taken_cnt,
  output logic [BITSIZE-1:0] nottaken_cnt
);

  // Only N(7), Z(6), F(5), L(2) and C(0) are architecturally kept in the PSR.
  localparam logic [BITSIZE-1:0] FLAG_MASK = BITSIZE'(16'h00E5);

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_HI = 4'h4, COND_LS = 4'h5, COND_GT = 4'h6, COND_LE = 4'h7,
    COND_FS = 4'h8, COND_FC = 4'h9, COND_LO = 4'hA, COND_HS = 4'hB,
    COND_LT = 4'hC, COND_GE = 4'hD, COND_UC = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Handshake: a request transfers on a cycle where req_valid & req_ready;
  // a decision transfers on a cycle where br_valid & br_ready. br_* stay stable
  // while br_valid=1 and br_ready=0.
  logic accept;
  logic cond_true;
  logic c_eff, l_eff, f_eff, z_eff, n_eff;

  assign req_ready = !(flags_pending && !flags_we) && (!br_valid || br_ready);
  assign accept    = req_valid && req_ready;

  // A flag write in the accept cycle bypasses the PSR so the branch sees it.
  always_comb begin
    c_eff = psr[0];
    l_eff = psr[2];
    f_eff = psr[5];
    z_eff = psr[6];
    n_eff = psr[7];
    if (flags_we) begin
      c_eff = flags_in[0];
      l_eff = flags_in[2];
      f_eff = flags_in[5];
      z_eff = flags_in[6];
      n_eff = flags_in[7];
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(req_cond))
      COND_EQ: cond_true = z_eff;
      COND_NE: cond_true = !z_eff;
      COND_CS: cond_true = c_eff;
      COND_CC: cond_true = !c_eff;
      COND_HI: cond_true = l_eff;
      COND_LS: cond_true = !l_eff;
      COND_GT: cond_true = n_eff;
      COND_LE: cond_true = !n_eff;
      COND_FS: cond_true = f_eff;
      COND_FC: cond_true = !f_eff;
      COND_LO: cond_true = !l_eff && !z_eff;
      COND_HS: cond_true = l_eff || z_eff;
      COND_LT: cond_true = !n_eff && !z_eff;
      COND_GE: cond_true = n_eff || z_eff;
      COND_UC: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr <= '0;
    end else if (flags_we) begin
      psr <= flags_in & FLAG_MASK;
    end
  end

  // Single-entry output slot; reloads on the same edge it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_valid  <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else if (accept) begin
      br_valid  <= 1'b1;
      br_taken  <= cond_true;
      br_target <= req_target;
    end else if (br_ready) begin
      br_valid  <= 1'b0;
    end
  end

  if (CNT_EN != 0) begin : g_cnt
    logic [BITSIZE-1:0] taken_q;
    logic [BITSIZE-1:0] nottaken_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        taken_q    <= '0;
        nottaken_q <= '0;
      end else if (accept) begin
        if (cond_true) begin
          if (taken_q != '1) taken_q <= taken_q + BITSIZE'(1);
        end else begin
          if (nottaken_q != '1) nottaken_q <= nottaken_q + BITSIZE'(1);
        end
      end
    end

    assign taken_cnt    = taken_q;
    assign nottaken_cnt = nottaken_q;
  end else begin : g_nocnt
    assign taken_cnt    = '0;
    assign nottaken_cnt = '0;
  end

endmodule

// File: tb/tb_psr_branch_resolver.sv
// Bench for psr_branch_resolver: vector table, hand sequences for stall,
// backpressure, saturation and async reset, then randomized scoreboard run.
module tb_psr_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic [15:0] flags_in;
  logic        flags_we;
  logic        flags_pending;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cond;
  logic [15:0] req_target;
  logic        br_valid;
  logic        br_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] psr;
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;

  logic        n_req_ready, n_br_valid, n_br_taken;
  logic [15:0] n_br_target, n_psr, n_taken_cnt, n_nottaken_cnt;

  logic [7:0]  s_flags_in;
  logic        s_flags_we, s_flags_pending, s_req_valid, s_req_ready;
  logic [3:0]  s_req_cond;
  logic [7:0]  s_req_target;
  logic        s_br_valid, s_br_ready, s_br_taken;
  logic [7:0]  s_br_target, s_psr, s_taken_cnt, s_nottaken_cnt;

  int total = 0;
  int bad   = 0;

  psr_branch_resolver #(.BITSIZE(16), .CNT_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
    .flags_pending(flags_pending), .req_valid(req_valid), .req_ready(req_ready),
    .req_cond(req_cond), .req_target(req_target), .br_valid(br_valid),
    .br_ready(br_ready), .br_taken(br_taken), .br_target(br_target), .psr(psr),
    .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
  );

  psr_branch_resolver #(.BITSIZE(16), .CNT_EN(0)) u_nocnt (
    .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
    .flags_pending(flags_pending), .req_valid(req_valid), .req_ready(n_req_ready),
    .req_cond(req_cond), .req_target(req_target), .br_valid(n_br_valid),
    .br_ready(br_ready), .br_taken(n_br_taken), .br_target(n_br_target), .psr(n_psr),
    .taken_cnt(n_taken_cnt), .nottaken_cnt(n_nottaken_cnt)
  );

  psr_branch_resolver #(.BITSIZE(8), .CNT_EN(1)) u_small (
    .clk(clk), .rst_n(rst_n), .flags_in(s_flags_in), .flags_we(s_flags_we),
    .flags_pending(s_flags_pending), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_cond(s_req_cond), .req_target(s_req_target), .br_valid(s_br_valid),
    .br_ready(s_br_ready), .br_taken(s_br_taken), .br_target(s_br_target), .psr(s_psr),
    .taken_cnt(s_taken_cnt), .nottaken_cnt(s_nottaken_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flags_in = '0; flags_we = 0; flags_pending = 0; req_valid = 0;
    req_cond = '0; req_target = '0; br_ready = 1;
    s_flags_in = '0; s_flags_we = 0; s_flags_pending = 0; s_req_valid = 0;
    s_req_cond = '0; s_req_target = '0; s_br_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference condition evaluation straight from the condition-code table.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [15:0] f);
    logic c, l, fo, z, n;
    c = f[0]; l = f[2]; fo = f[5]; z = f[6]; n = f[7];
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return l;
      4'h5: return !l;
      4'h6: return n;
      4'h7: return !n;
      4'h8: return fo;
      4'h9: return !fo;
      4'hA: return !l && !z;
      4'hB: return l || z;
      4'hC: return !n && !z;
      4'hD: return n || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic        we;
    logic [15:0] flags;
    logic [3:0]  cond;
    logic [15:0] target;
    logic        exp_taken;
    logic [15:0] exp_psr;
  } vec_t;

  vec_t vecs[20];
  logic [16:0] exp_q[$];

  initial begin
    int exp_t, exp_n;
    logic exp_ready;
    logic [15:0] m_psr;
    logic [15:0] eff;
    logic t;

    vecs[0]  = '{1'b1, 16'h0040, 4'h0, 16'h1234, 1'b1, 16'h0040};
    vecs[1]  = '{1'b1, 16'hFFFF, 4'hA, 16'h1111, 1'b0, 16'h00E5};
    vecs[2]  = '{1'b0, 16'h0040, 4'hB, 16'h2222, 1'b1, 16'h00E5};
    vecs[3]  = '{1'b1, 16'h0001, 4'h2, 16'h3333, 1'b1, 16'h0001};
    vecs[4]  = '{1'b0, 16'hFFFF, 4'h3, 16'h4444, 1'b0, 16'h0001};
    vecs[5]  = '{1'b1, 16'h0020, 4'h8, 16'h5555, 1'b1, 16'h0020};
    vecs[6]  = '{1'b0, 16'h0000, 4'h9, 16'h6666, 1'b0, 16'h0020};
    vecs[7]  = '{1'b1, 16'h0080, 4'h6, 16'h7777, 1'b1, 16'h0080};
    vecs[8]  = '{1'b0, 16'h0000, 4'h7, 16'h8888, 1'b0, 16'h0080};
    vecs[9]  = '{1'b0, 16'h0000, 4'hC, 16'h9999, 1'b0, 16'h0080};
    vecs[10] = '{1'b1, 16'h0000, 4'hC, 16'hAAAA, 1'b1, 16'h0000};
    vecs[11] = '{1'b0, 16'h0000, 4'hD, 16'hBBBB, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 16'h0000, 4'hE, 16'hCCCC, 1'b1, 16'h0000};
    vecs[13] = '{1'b0, 16'h0000, 4'hF, 16'hDDDD, 1'b0, 16'h0000};
    vecs[14] = '{1'b1, 16'hFF1A, 4'h1, 16'hEEEE, 1'b1, 16'h0000};
    vecs[15] = '{1'b1, 16'h0004, 4'h4, 16'hF00F, 1'b1, 16'h0004};
    vecs[16] = '{1'b0, 16'h0000, 4'h5, 16'h0F0F, 1'b0, 16'h0004};
    vecs[17] = '{1'b0, 16'h0000, 4'hA, 16'h1357, 1'b0, 16'h0004};
    vecs[18] = '{1'b1, 16'h0040, 4'hA, 16'h2468, 1'b0, 16'h0040};
    vecs[19] = '{1'b1, 16'h0000, 4'h0, 16'hFFFE, 1'b0, 16'h0000};

    // reset state
    do_reset();
    check("rst_psr", psr, 0);
    check("rst_br_valid", br_valid, 0);
    check("rst_br_taken", br_taken, 0);
    check("rst_br_target", br_target, 0);
    check("rst_taken_cnt", taken_cnt, 0);
    check("rst_nottaken_cnt", nottaken_cnt, 0);
    check("rst_req_ready", req_ready, 1);

    // vector table, back-to-back with br_ready=1
    exp_t = 0; exp_n = 0;
    for (int i = 0; i < 20; i++) begin
      flags_we = vecs[i].we; flags_in = vecs[i].flags;
      req_valid = 1; req_cond = vecs[i].cond; req_target = vecs[i].target;
      br_ready = 1;
      @(negedge clk);
      check($sformatf("vec%0d_req_ready", i), req_ready, 1);
      tick();
      req_valid = 0; flags_we = 0;
      if (vecs[i].exp_taken) exp_t++; else exp_n++;
      check($sformatf("vec%0d_br_valid", i), br_valid, 1);
      check($sformatf("vec%0d_br_taken", i), br_taken, vecs[i].exp_taken);
      check($sformatf("vec%0d_br_target", i), br_target, vecs[i].target);
      check($sformatf("vec%0d_psr", i), psr, vecs[i].exp_psr);
      check($sformatf("vec%0d_taken_cnt", i), taken_cnt, exp_t);
      check($sformatf("vec%0d_nottaken_cnt", i), nottaken_cnt, exp_n);
    end

    // hazard stall, then write+request in the same cycle
    flags_pending = 1; req_valid = 1; req_cond = 4'h4; req_target = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_req_ready", i), req_ready, 0);
      tick();
      check($sformatf("stall%0d_br_valid", i), br_valid, 0);
    end
    flags_we = 1; flags_in = 16'h0004;
    @(negedge clk);
    check("unstall_req_ready", req_ready, 1);
    tick();
    flags_we = 0; flags_pending = 0;
    check("unstall_br_valid", br_valid, 1);
    check("unstall_br_taken", br_taken, 1);
    check("unstall_br_target", br_target, 16'h4321);

    // backpressure: decision must hold, no new accept
    br_ready = 0; req_cond = 4'hF; req_target = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_req_ready", i), req_ready, 0);
      tick();
      check($sformatf("hold%0d_br_valid", i), br_valid, 1);
      check($sformatf("hold%0d_br_taken", i), br_taken, 1);
      check($sformatf("hold%0d_br_target", i), br_target, 16'h4321);
    end
    br_ready = 1; req_cond = 4'hF; req_target = 16'h2000;
    tick();
    check("b2b_nv_valid", br_valid, 1);
    check("b2b_nv_taken", br_taken, 0);
    check("b2b_nv_target", br_target, 16'h2000);
    req_cond = 4'hE; req_target = 16'h3000;
    tick();
    check("b2b_uc_valid", br_valid, 1);
    check("b2b_uc_taken", br_taken, 1);
    check("b2b_uc_target", br_target, 16'h3000);
    req_valid = 0;
    tick();
    check("drain_br_valid", br_valid, 0);
    check("drain_br_target_held", br_target, 16'h3000);

    // asynchronous reset with a decision pending
    flags_we = 1; flags_in = 16'h0040; req_valid = 1; req_cond = 4'h0; req_target = 16'h5A5A;
    tick();
    flags_we = 0; req_valid = 0; br_ready = 0;
    check("pre_arst_br_valid", br_valid, 1);
    check("pre_arst_psr", psr, 16'h0040);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("arst_br_valid", br_valid, 0);
    check("arst_br_taken", br_taken, 0);
    check("arst_br_target", br_target, 0);
    check("arst_psr", psr, 0);
    check("arst_taken_cnt", taken_cnt, 0);
    check("arst_nottaken_cnt", nottaken_cnt, 0);
    check("arst_req_ready", req_ready, 1);
    #1 rst_n = 1;

    // saturation on an 8-bit instance
    do_reset();
    s_req_valid = 1; s_br_ready = 1; s_req_cond = 4'hF; s_req_target = 8'h55;
    repeat (255) tick();
    check("sat_nt_at_max", s_nottaken_cnt, 8'hFF);
    repeat (5) tick();
    check("sat_nt_hold", s_nottaken_cnt, 8'hFF);
    check("sat_nt_taken_zero", s_taken_cnt, 0);
    s_req_cond = 4'hE;
    repeat (254) tick();
    check("sat_t_below_max", s_taken_cnt, 8'hFE);
    repeat (6) tick();
    check("sat_t_hold", s_taken_cnt, 8'hFF);
    s_req_valid = 0;

    // randomized run against the scoreboard model
    do_reset();
    m_psr = '0; exp_t = 0; exp_n = 0;
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      flags_we      = ($urandom_range(0, 9) < 3);
      flags_in      = 16'($urandom());
      flags_pending = ($urandom_range(0, 9) < 2);
      req_valid     = ($urandom_range(0, 9) < 7);
      req_cond      = 4'($urandom_range(0, 15));
      req_target    = 16'($urandom());
      br_ready      = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      exp_ready = !(flags_pending && !flags_we) && (exp_q.size() == 0 || br_ready);
      check("rnd_req_ready", req_ready, exp_ready);
      check("rnd_br_valid", br_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("rnd_br_taken", br_taken, exp_q[0][16]);
        check("rnd_br_target", br_target, exp_q[0][15:0]);
      end
      if (exp_q.size() != 0 && br_ready) void'(exp_q.pop_front());
      if (req_valid && exp_ready) begin
        eff = flags_we ? flags_in : m_psr;
        t = cond_eval(req_cond, eff);
        exp_q.push_back({t, req_target});
        if (t) exp_t = (exp_t < 65535) ? exp_t + 1 : exp_t;
        else   exp_n = (exp_n < 65535) ? exp_n + 1 : exp_n;
      end
      if (flags_we) m_psr = flags_in & 16'h00E5;
      tick();
      check("rnd_psr", psr, m_psr);
      check("rnd_taken_cnt", taken_cnt, exp_t);
      check("rnd_nottaken_cnt", nottaken_cnt, exp_n);
    end
    check("nocnt_taken_zero", n_taken_cnt, 0);
    check("nocnt_nottaken_zero", n_nottaken_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psr_branch_resolver.md
Name: psr_branch_resolver

Overview:
- Consumer end of the ALU flag interface.
- Latches the 16-bit ALU flags word into a processor status register (PSR) and resolves 4-bit branch condition codes against it.
- Returns a registered taken/not-taken decision to fetch through a valid/ready handshake.
- Sits between the ALU (aluparam) and the PC/fetch stage of the 16-bit datapath.

Parameters:
- BITSIZE, 16, width of flags word, branch target and taken/not-taken counters.
- CNT_EN, 1, 1 = statistics counters present; 0 = counters tied to 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flags_in  in  BITSIZE  ALU flags word. Bit 0 = C (carry), bit 2 = L (low), bit 5 = F (overflow), bit 6 = Z (zero), bit 7 = N (negative); other bits ignored.
- flags_we  in  1  latch flags_in into the PSR this cycle
- flags_pending  in  1  a flag-setting ALU op is in flight and the PSR is stale
- req_valid  in  1  branch request valid
- req_ready  out  1  resolver accepts a request this cycle
- req_cond  in  4  condition code
- req_target  in  BITSIZE  branch target address
- br_valid  out  1  decision valid
- br_ready  in  1  fetch consumes the decision
- br_taken  out  1  condition true
- br_target  out  BITSIZE  target echoed from the request
- psr  out  BITSIZE  current PSR; unused bits read 0
- taken_cnt  out  BITSIZE  saturating count of taken decisions
- nottaken_cnt  out  BITSIZE  saturating count of not-taken decisions

Behaviour:
- Reset (async, rst_n=0): psr=0, br_valid=0, br_taken=0, br_target=0, both counters=0. req_ready follows its combinational equation.
- PSR update:
  - On clk with flags_we=1, psr <= flags_in masked to bits {7,6,5,2,0}.
  - Otherwise psr holds.
- Condition codes (eff = flags used for evaluation):
  - 0000 EQ Z=1; 0001 NE Z=0
  - 0010 CS C=1; 0011 CC C=0
  - 0100 HI L=1; 0101 LS L=0
  - 0110 GT N=1; 0111 LE N=0
  - 1000 FS F=1; 1001 FC F=0
  - 1010 LO L=0&Z=0; 1011 HS L=1|Z=1
  - 1100 LT N=0&Z=0; 1101 GE N=1|Z=1
  - 1110 UC always true; 1111 NV never true
- Forwarding: if flags_we=1 in the accept cycle, eff = flags_in (same-cycle bypass); else eff = psr.
- Hazard stall: when flags_pending=1 and flags_we=0, req_ready=0.
- Output slot, single entry:
  - req_ready = !(flags_pending & !flags_we) & (!br_valid | br_ready).
  - Accept = req_valid & req_ready. On accept, next cycle br_valid=1 with br_taken and br_target registered. Latency is exactly 1 cycle.
  - br_valid=1 & br_ready=0: br_valid, br_taken and br_target hold stable; no new accept.
  - br_valid=1 & br_ready=1 & new accept: the slot reloads back-to-back, giving 1 decision/cycle throughput.
  - br_ready=1 with no accept: br_valid <= 0.
- Counters:
  - Increment on accept: taken_cnt if the condition is true, else nottaken_cnt.
  - Saturate at all-ones; no wrap.
  - CNT_EN=0: both outputs tied to 0.
- Reset mid-handshake: the pending decision is dropped (br_valid=0) and the PSR is cleared.
- req_valid=0: no state change except the PSR write.

Test Plan:
- Reset then flags_we with flags_in=16'h0040 (Z), req EQ with target 16'h1234 -> next cycle br_valid=1, br_taken=1, br_target=16'h1234, psr=16'h0040, taken_cnt=1.
- flags_we with flags_in=16'hFFFF and req LO in the same cycle -> bypass used, br_taken=0; psr=16'h00E5.
- flags_pending=1 with req_valid=1 for 3 cycles -> req_ready=0, br_valid stays 0. Then flags_we with 16'h0004 (L) and req HI -> taken.
- br_ready=0 for 4 cycles after a decision -> br_* held stable, req_ready=0. br_ready=1 with back-to-back NV, UC requests -> not-taken then taken on consecutive cycles.
- Preload nottaken_cnt near saturation via 16'hFFFF NV requests -> count holds at 16'hFFFF.
- rst_n low while br_valid=1 -> br_valid, psr and counters are 0 immediately, before any clock edge.
